// File: rtl/mips_regfile_sb_pkg.sv
// Shared definitions for the MIPS register file with busy scoreboard:
// default widths, architectural register names and the writability rule
// that both the data array and the scoreboard must agree on.
package mips_regfile_sb_pkg;

  // Default geometry of the classic MIPS register file
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural register indices
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

  // A register index is writable (and therefore readable as stored data and
  // eligible to become busy) when it is implemented and is not a hardwired r0.
  // Any index failing this rule reads 0, is never busy and drops writes.
  function automatic logic reg_writable(input logic [31:0] idx,
                                        input int unsigned num_regs,
                                        input logic        zero_reg);
    return (!zero_reg || (idx != 32'(REG_ZERO))) && (idx < 32'(num_regs));
  endfunction

endpackage : mips_regfile_sb_pkg

// File: rtl/mips_regfile_sb_scoreboard.sv
// Busy scoreboard for the register file: one busy bit per implemented
// register, set when decode issues a destination and cleared when writeback
// retires it. Also produces the WAW-stall signal issue_ready and a registered
// count of busy registers.
module mips_scoreboard
  import mips_regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = 1 << ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              issue_ready,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     cnt_d;

  logic issue_ok;
  logic clr_ok;
  logic set_en;
  logic clr_en;

  // Busy bit of an index; unimplemented or hardwired indices are never busy.
  function automatic logic busy_at(input logic [ADDR_W-1:0] idx);
    return reg_writable(32'(idx), NUM_REGS, ZR) ? busy_q[idx] : 1'b0;
  endfunction

  assign issue_ok = reg_writable(32'(issue_rd), NUM_REGS, ZR);
  assign clr_ok   = clr && reg_writable(32'(clr_rd), NUM_REGS, ZR);

  // A busy destination may be re-issued in the very cycle its producer
  // writes back, so writeback to the same index lifts the stall.
  assign issue_ready = !busy_at(issue_rd) || (clr && (clr_rd == issue_rd));

  // set_en only fires when the bit is 0 or is being cleared this cycle;
  // clr_en only counts a clear that actually drops a 1.
  assign set_en = issue && issue_ready && issue_ok;
  assign clr_en = clr_ok && busy_at(clr_rd);

  assign rs_busy  = busy_at(rs);
  assign rt_busy  = busy_at(rt);
  assign busy_cnt = cnt_q;

  // Per-register next busy bit: a new issue wins over a same-cycle clear.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      assign busy_d[gi] = (set_en && (issue_rd == ADDR_W'(gi))) ||
                          (busy_q[gi] && !(clr_ok && (clr_rd == ADDR_W'(gi))));
    end
  endgenerate

  // Busy count tracks the population of busy_q one step at a time.
  always_comb begin
    cnt_d = cnt_q;
    case ({set_en, clr_en})
      2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Scoreboard state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule : mips_scoreboard

// File: rtl/mips_regfile_sb.sv
// Parametrised MIPS register file: two combinational read ports, one
// synchronous write port and a per-register busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a writeback in
// the current cycle is forwarded to a matching read port (data and busy).
module mips_regfile_sb
  import mips_regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = 1 << ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              write,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] in,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              wr_en;
  logic              rs_ok;
  logic              rt_ok;
  logic [DATA_W-1:0] arr_a;
  logic [DATA_W-1:0] arr_b;
  logic              sb_rs_busy;
  logic              sb_rt_busy;

  assign wr_en = write && reg_writable(32'(rd), NUM_REGS, ZR);
  assign rs_ok = reg_writable(32'(rs), NUM_REGS, ZR);
  assign rt_ok = reg_writable(32'(rt), NUM_REGS, ZR);

  mips_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue),
    .issue_rd    (issue_rd),
    .clr         (write),
    .clr_rd      (rd),
    .rs          (rs),
    .rt          (rt),
    .rs_busy     (sb_rs_busy),
    .rt_busy     (sb_rt_busy),
    .issue_ready (issue_ready),
    .busy_cnt    (busy_cnt)
  );

  // Register storage: each entry clears on reset and loads on a matching
  // writeback. A hardwired r0 is never enabled, so it holds its reset zero.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_q[gi] <= '0;
        end else if (wr_en && (rd == ADDR_W'(gi))) begin
          regs_q[gi] <= in;
        end
      end
    end
  endgenerate

  // Array read muxes; indices that are not backed by storage read as 0.
  always_comb begin
    arr_a = '0;
    arr_b = '0;
    if (rs_ok) arr_a = regs_q[rs];
    if (rt_ok) arr_b = regs_q[rt];
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_a;
  logic byp_b;

  assign byp_a = wr_en && (rd == rs);
  assign byp_b = wr_en && (rd == rt);

  // Forward the in-flight writeback so the consumer sees it this cycle.
  always_comb begin
    A       = byp_a ? in : arr_a;
    B       = byp_b ? in : arr_b;
    rs_busy = sb_rs_busy && !byp_a;
    rt_busy = sb_rt_busy && !byp_b;
  end
`else
  // Outputs show pre-edge state; a result is visible one cycle after writeback.
  always_comb begin
    A       = arr_a;
    B       = arr_b;
    rs_busy = sb_rs_busy;
    rt_busy = sb_rt_busy;
  end
`endif

endmodule : mips_regfile_sb

// File: tb/tb_mips_regfile_sb.sv
// Self-checking bench for mips_regfile_sb (default parameters). A plain
// array model of registers and busy flags predicts every output each cycle.
module tb_mips_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs, rt, issue_rd, rd;
  logic [DW-1:0] A, B, in;
  logic          rs_busy, rt_busy, issue, issue_ready, write;
  logic [AW:0]   busy_cnt;

  always #5 clk = ~clk;

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .A(A), .B(B),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .issue(issue), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .write(write), .rd(rd), .in(in), .busy_cnt(busy_cnt)
  );

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d: got %0h want %0h", tag, txn, obs, exp);
    end
  endtask

  function automatic bit m_ok(input logic [AW-1:0] i);
    return (i != 0) && (int'(i) < NR);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // One cycle: drive, check combinational outputs, clock, advance the model.
  task automatic step(input logic r, input logic [AW-1:0] a_rs, input logic [AW-1:0] a_rt,
                      input logic iss, input logic [AW-1:0] ird,
                      input logic wr, input logic [AW-1:0] wrd, input logic [DW-1:0] wdat);
    logic [DW-1:0] ea, eb;
    logic          eab, ebb, erdy, wok;
    rst = r; rs = a_rs; rt = a_rt; issue = iss; issue_rd = ird;
    write = wr; rd = wrd; in = wdat;
    #1;
    wok  = wr && m_ok(wrd);
    ea   = m_ok(a_rs) ? m_regs[a_rs] : '0;
    eb   = m_ok(a_rt) ? m_regs[a_rt] : '0;
    eab  = m_ok(a_rs) && m_busy[a_rs];
    ebb  = m_ok(a_rt) && m_busy[a_rt];
`ifdef REGFILE_BYPASS_EN
    if (wok && wrd == a_rs) begin ea = wdat; eab = 1'b0; end
    if (wok && wrd == a_rt) begin eb = wdat; ebb = 1'b0; end
`endif
    erdy = !(m_ok(ird) && m_busy[ird]) || (wr && wrd == ird);
    check("A", 64'(A), 64'(ea));
    check("B", 64'(B), 64'(eb));
    check("rs_busy", 64'(rs_busy), 64'(eab));
    check("rt_busy", 64'(rt_busy), 64'(ebb));
    check("issue_ready", 64'(issue_ready), 64'(erdy));
    check("busy_cnt", 64'(busy_cnt), 64'(m_count()));
    $display("txn %0d rst=%0b rs=%0d rt=%0d iss=%0b/%0d wr=%0b/%0d/%0h A=%0h B=%0h rdy=%0b cnt=%0d",
             txn, r, a_rs, a_rt, iss, ird, wr, wrd, wdat, A, B, issue_ready, busy_cnt);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    end else begin
      if (wok) begin m_regs[wrd] = wdat; m_busy[wrd] = 1'b0; end
      if (iss && erdy && m_ok(ird)) m_busy[ird] = 1'b1;
    end
    txn++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    rst = 1'b1; rs = '0; rt = '0; issue = 1'b0; issue_rd = '0; write = 1'b0; rd = '0; in = '0;
    @(posedge clk); #1;

    // reset then read
    step(1'b0, 5'd10, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    // writes, including a dropped write to r0
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'd11);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 32'd22);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'd33);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'd44);
    step(1'b0, 5'd0, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd3, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    // issue r7, observe busy, retire it
    step(1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h55);
    step(1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    // WAW stall, then re-issue alongside writeback
    step(1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 32'h66);
    step(1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    // read during write of the same register
    step(1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'hABCD);
    step(1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    // issue r0 is a no-op
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0);
    // issue r1..r3, then reset with a write to r1
    step(1'b0, 5'd1, 5'd2, 1'b1, 5'd1, 1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd1, 5'd2, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd1, 32'h77);
    step(1'b0, 5'd1, 5'd7, 1'b1, 5'd1, 1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);

    // randomized traffic concentrated on a few registers to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] r_rs, r_rt, r_ird, r_rd;
      r_rs  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      r_rt  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      r_ird = ($urandom_range(0, 9) == 0) ? AW'(31)       : AW'($urandom_range(0, 7));
      r_rd  = ($urandom_range(0, 9) == 0) ? AW'(31)       : AW'($urandom_range(0, 7));
      step(($urandom_range(0, 59) == 0), r_rs, r_rt, 1'($urandom_range(0, 1)), r_ird,
           1'($urandom_range(0, 2) == 0), r_rd, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mips_regfile_sb
